dlatch_write_sequencer: RTL and testbench

- Clocked write controller that drives an external binary gated D-latch bank and reads it back: latch_d data lines, latch_en clock/enable, latch_q/latch_qn readback.
- Accepts words over a valid/ready handshake.
- Sequences setup -> enable pulse -> hold on the latch inputs, then samples Q/notQ and checks that the stored word matches and that the Q/notQ pairs are complementary.
- Sits between synchronous logic and asynchronous latch storage.

---
 rtl/dlatch_wr_pkg.sv | 26 ++
 rtl/dlatch_readback_check.sv | 63 ++++++
 rtl/dlatch_write_sequencer.sv | 178 +++++++++++++++++
 tb/tb_dlatch_write_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlatch_wr_pkg.sv
// Shared types and helpers for the gated D-latch write sequencer.
// Contents:
//   state_t   - sequencer state encoding
//   cnt_width - phase counter width for the given phase lengths
package dlatch_wr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK
    } state_t;

    // Bits needed to hold the longest phase length; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dlatch_readback_check.sv
// Latch readback checker: compares the Q/notQ readback against the driven
// data word and flags any mismatch or non-complementary Q/notQ pair
// (including the illegal Q=notQ=0 state).
// Optional macro DLATCH_SYNC_READBACK_EN inserts a 2-flop synchronizer on
// latch_q/latch_qn before the compare.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (synchronizer only)
//   latch_d   - data word currently driven to the latch bank
//   latch_q   - Q readback
//   latch_qn  - notQ readback
//   q_c       - readback word as seen by the compare (combinational)
//   err_c     - mismatch / illegal-state flag (combinational)
module dlatch_readback_check
    import dlatch_wr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] latch_d,
    input  logic [WIDTH-1:0] latch_q,
    input  logic [WIDTH-1:0] latch_qn,
    output logic [WIDTH-1:0] q_c,
    output logic             err_c
);

    logic [WIDTH-1:0] qn_v;

`ifdef DLATCH_SYNC_READBACK_EN
    logic [WIDTH-1:0] q_meta;
    logic [WIDTH-1:0] q_sync;
    logic [WIDTH-1:0] qn_meta;
    logic [WIDTH-1:0] qn_sync;

    // Two-stage synchronizer for the asynchronous latch outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_meta  <= '0;
            q_sync  <= '0;
            qn_meta <= '0;
            qn_sync <= '0;
        end else begin
            q_meta  <= latch_q;
            q_sync  <= q_meta;
            qn_meta <= latch_qn;
            qn_sync <= qn_meta;
        end
    end

    assign q_c  = q_sync;
    assign qn_v = qn_sync;
`else
    logic unused_sync_ports;

    assign unused_sync_ports = clk | rst;
    assign q_c  = latch_q;
    assign qn_v = latch_qn;
`endif

    // Any equal Q/notQ bit pair is an error, as is a stored-word mismatch.
    assign err_c = (q_c != latch_d) | (|(q_c ~^ qn_v));

endmodule

// File: rtl/dlatch_write_sequencer.sv
// Write sequencer for an external gated D-latch bank: accepts a word on a
// valid/ready handshake, drives setup -> enable pulse -> hold on the latch
// inputs, then samples Q/notQ and reports the stored word and an error flag.
// Optional macro DLATCH_SYNC_READBACK_EN synchronizes the readback and
// stretches CHECK to 3 cycles.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   wr_valid  - write request
//   wr_ready  - sequencer idle, request accepted on wr_valid & wr_ready
//   wr_data   - word to store
//   latch_d   - latch data lines
//   latch_en  - latch enable
//   latch_q   - latch Q readback
//   latch_qn  - latch notQ readback
//   rd_data   - latch_q sampled at the end of the last completed write
//   done      - one-cycle completion pulse
//   err       - result flag of the last completed write
module dlatch_write_sequencer
    import dlatch_wr_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] latch_d,
    output logic             latch_en,
    input  logic [WIDTH-1:0] latch_q,
    input  logic [WIDTH-1:0] latch_qn,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             err
);

`ifdef DLATCH_SYNC_READBACK_EN
    localparam int unsigned CHECK_CYC = 3;
`else
    localparam int unsigned CHECK_CYC = 1;
`endif

    localparam int unsigned CNT_W =
        cnt_width(SETUP_CYC, PULSE_CYC, (HOLD_CYC > CHECK_CYC) ? HOLD_CYC : CHECK_CYC);

    // Counter load values: each phase counts down from length-1 to zero.
    localparam logic [CNT_W-1:0] SETUP_LD = (SETUP_CYC > 0) ? CNT_W'(SETUP_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] PULSE_LD = (PULSE_CYC > 0) ? CNT_W'(PULSE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LD  = (HOLD_CYC > 0)  ? CNT_W'(HOLD_CYC - 1)  : '0;
    localparam logic [CNT_W-1:0] CHECK_LD = CNT_W'(CHECK_CYC - 1);

    if (PULSE_CYC == 0) begin : g_pulse_cyc_check
        $error("dlatch_write_sequencer: PULSE_CYC must be at least 1");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] latch_d_next;
    logic             latch_en_next;
    logic             wr_ready_next;
    logic [WIDTH-1:0] rd_data_next;
    logic             done_next;
    logic             err_next;
    logic [WIDTH-1:0] q_c;
    logic             err_c;

    dlatch_readback_check #(
        .WIDTH(WIDTH)
    ) u_check (
        .clk      (clk),
        .rst      (rst),
        .latch_d  (latch_d),
        .latch_q  (latch_q),
        .latch_qn (latch_qn),
        .q_c      (q_c),
        .err_c    (err_c)
    );

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            latch_d  <= '0;
            latch_en <= 1'b0;
            wr_ready <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            latch_d  <= latch_d_next;
            latch_en <= latch_en_next;
            wr_ready <= wr_ready_next;
            rd_data  <= rd_data_next;
            done     <= done_next;
            err      <= err_next;
        end
    end

    // Next-state and next-output logic; latch_d only loads in IDLE.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        latch_d_next = latch_d;
        rd_data_next = rd_data;
        err_next     = err;
        done_next    = 1'b0;

        unique case (state)
            IDLE: begin
                if (wr_valid && wr_ready) begin
                    latch_d_next = wr_data;
                    if (SETUP_CYC > 0) begin
                        state_next = SETUP;
                        cnt_next   = SETUP_LD;
                    end else begin
                        state_next = PULSE;
                        cnt_next   = PULSE_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    if (HOLD_CYC > 0) begin
                        state_next = HOLD;
                        cnt_next   = HOLD_LD;
                    end else begin
                        state_next = CHECK;
                        cnt_next   = CHECK_LD;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = CHECK;
                    cnt_next   = CHECK_LD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            CHECK: begin
                if (cnt == '0) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    rd_data_next = q_c;
                    err_next     = err_c;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Enable and ready follow the state being entered, so both are glitch-free flops.
        latch_en_next = (state_next == PULSE);
        wr_ready_next = (state_next == IDLE);
    end

endmodule

// File: tb/tb_dlatch_write_sequencer.sv
// Self-checking bench for dlatch_write_sequencer with behavioural latch models.
// Main instance: default timing (SETUP=1, PULSE=2, HOLD=1).
// Second instance: SETUP=0, HOLD=0.
module tb_dlatch_write_sequencer;

`ifdef DLATCH_SYNC_READBACK_EN
    localparam int N_MAIN = 8;
    localparam int N_Z    = 6;
`else
    localparam int N_MAIN = 6;
    localparam int N_Z    = 4;
`endif

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic [7:0] latch_d;
    logic       latch_en;
    logic [7:0] latch_q;
    logic [7:0] latch_qn;
    logic [7:0] rd_data;
    logic       done;
    logic       err;

    logic       z_valid;
    logic       z_ready;
    logic [7:0] z_data;
    logic [7:0] z_latch_d;
    logic       z_latch_en;
    logic [7:0] z_latch_q;
    logic [7:0] z_latch_qn;
    logic [7:0] z_rd_data;
    logic       z_done;
    logic       z_err;

    logic [7:0] store_a;
    logic [7:0] store_z;
    logic [1:0] mode;     // 0 normal, 1 bit0 stuck-at-0, 2 Q=notQ=0

    int         checks;
    int         errors;
    logic [7:0] prev_rd;
    logic       prev_err;

    dlatch_write_sequencer u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .latch_d  (latch_d),
        .latch_en (latch_en),
        .latch_q  (latch_q),
        .latch_qn (latch_qn),
        .rd_data  (rd_data),
        .done     (done),
        .err      (err)
    );

    dlatch_write_sequencer #(
        .WIDTH     (8),
        .SETUP_CYC (0),
        .PULSE_CYC (2),
        .HOLD_CYC  (0)
    ) u_dut_z (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (z_valid),
        .wr_ready (z_ready),
        .wr_data  (z_data),
        .latch_d  (z_latch_d),
        .latch_en (z_latch_en),
        .latch_q  (z_latch_q),
        .latch_qn (z_latch_qn),
        .rd_data  (z_rd_data),
        .done     (z_done),
        .err      (z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transparent-high latch storage.
    always_latch begin
        if (latch_en) store_a = latch_d;
    end

    always_latch begin
        if (z_latch_en) store_z = z_latch_d;
    end

    // Q/notQ readback with optional fault injection.
    always_comb begin
        latch_q  = store_a;
        latch_qn = ~store_a;
        if (mode == 2'd1) begin
            latch_q[0]  = 1'b0;
            latch_qn[0] = 1'b1;
        end else if (mode == 2'd2) begin
            latch_q  = 8'h00;
            latch_qn = 8'h00;
        end
    end

    assign z_latch_q  = store_z;
    assign z_latch_qn = ~store_z;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!wr_ready && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 8'(wr_ready), 8'd1);
    endtask

    // One write on the main instance with a full per-cycle trace check.
    task automatic do_write(input string tag, input logic [7:0] data,
                            input logic [7:0] exp_rd, input logic exp_err);
        wait_ready({tag, "_rdy0"});
        wr_valid = 1'b1;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
        wr_data  = ~data;
        for (int k = 1; k <= N_MAIN; k++) begin
            chk($sformatf("%s_en+%0d", tag, k), 8'(latch_en), 8'(k == 2 || k == 3));
            chk($sformatf("%s_d+%0d", tag, k), latch_d, data);
            chk($sformatf("%s_done+%0d", tag, k), 8'(done), 8'(k == N_MAIN));
            chk($sformatf("%s_rdy+%0d", tag, k), 8'(wr_ready), 8'(k == N_MAIN));
            if (k < N_MAIN) begin
                chk($sformatf("%s_errhold+%0d", tag, k), 8'(err), 8'(prev_err));
                chk($sformatf("%s_rdhold+%0d", tag, k), rd_data, prev_rd);
                tick();
            end else begin
                chk({tag, "_rd"}, rd_data, exp_rd);
                chk({tag, "_err"}, 8'(err), 8'(exp_err));
            end
        end
        prev_rd  = exp_rd;
        prev_err = exp_err;
        tick();
        chk({tag, "_done_end"}, 8'(done), 8'd0);
    endtask

    initial begin
        int pulses;
        checks   = 0;
        errors   = 0;
        prev_rd  = 8'h00;
        prev_err = 1'b0;
        mode     = 2'd0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        z_valid  = 1'b0;
        z_data   = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 8'(wr_ready), 8'd0);
        chk("rst_en", 8'(latch_en), 8'd0);
        chk("rst_d", latch_d, 8'h00);
        chk("rst_rd", rd_data, 8'h00);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready_after", 8'(wr_ready), 8'd1);

        // Normal write
        do_write("a5", 8'hA5, 8'hA5, 1'b0);

        // Bit0 stuck-at-0, then a word that does not exercise bit0
        mode = 2'd1;
        do_write("stuck_a5", 8'hA5, 8'hA4, 1'b1);
        do_write("stuck_3c", 8'h3C, 8'h3C, 1'b0);

        // Illegal state Q=notQ=0 with a matching word: only the pair check fires
        mode = 2'd2;
        do_write("illegal", 8'h00, 8'h00, 1'b1);
        mode = 2'd0;

        // Back-to-back: valid held, data changes while busy
        wait_ready("b2b_rdy0");
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        tick();
        wr_data  = 8'h22;
        for (int k = 1; k <= 2 * N_MAIN; k++) begin
            chk($sformatf("b2b_rdy+%0d", k), 8'(wr_ready), 8'(k == N_MAIN || k == 2 * N_MAIN));
            chk($sformatf("b2b_done+%0d", k), 8'(done), 8'(k == N_MAIN || k == 2 * N_MAIN));
            chk($sformatf("b2b_d+%0d", k), latch_d, (k <= N_MAIN) ? 8'h11 : 8'h22);
            if (k == N_MAIN) begin
                chk("b2b_rd1", rd_data, 8'h11);
                chk("b2b_err1", 8'(err), 8'd0);
            end
            if (k == 2 * N_MAIN) begin
                chk("b2b_rd2", rd_data, 8'h22);
                chk("b2b_err2", 8'(err), 8'd0);
                wr_valid = 1'b0;
            end else begin
                tick();
            end
        end
        tick();
        chk("b2b_done_end", 8'(done), 8'd0);

        // Reset during the first PULSE cycle
        wait_ready("rst_mid_rdy0");
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("rst_mid_en_pulse", 8'(latch_en), 8'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_en", 8'(latch_en), 8'd0);
        chk("rst_mid_ready", 8'(wr_ready), 8'd0);
        chk("rst_mid_done", 8'(done), 8'd0);
        rst = 1'b0;
        tick();
        chk("rst_mid_ready_after", 8'(wr_ready), 8'd1);
        pulses = 0;
        for (int k = 0; k < N_MAIN + 2; k++) begin
            if (done) pulses++;
            tick();
        end
        chk("rst_mid_no_done", 8'(pulses), 8'd0);
        prev_rd  = 8'h00;
        prev_err = 1'b0;
        do_write("ff", 8'hFF, 8'hFF, 1'b0);

        // Zero setup/hold instance
        chk("z_ready", 8'(z_ready), 8'd1);
        z_valid = 1'b1;
        z_data  = 8'h5A;
        tick();
        z_valid = 1'b0;
        for (int k = 1; k <= N_Z; k++) begin
            chk($sformatf("z_en+%0d", k), 8'(z_latch_en), 8'(k == 1 || k == 2));
            chk($sformatf("z_done+%0d", k), 8'(z_done), 8'(k == N_Z));
            if (k == N_Z) begin
                chk("z_rd", z_rd_data, 8'h5A);
                chk("z_err", 8'(z_err), 8'd0);
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
